spi_reg_bank: RTL

Parametrised SPI mode-0 register bank: the successor to the fixed five-register write-only SPI peripheral. It exposes NUM_REGS control registers of DATA_W bits to an off-chip controller, supports both write and read-back (CIPO), and checks frame length. All SPI pins are oversampled in the system clock domain; all state changes on `clk`. It sits between the chip pins and the PWM/output-enable logic.

---
 rtl/spi_reg_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_reg_bank.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register bank: FSM state encoding,
// frame-format constants and the frame length function.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        DATA    = 3'd2,
        FULL    = 3'd3,
        OVERRUN = 3'd4
    } state_t;

    localparam logic RW_WRITE = 1'b1;

    function automatic int frame_bits(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a history
// flop so rising and falling edges can be detected in the clk domain.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Reset value matches the idle pin level so release never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing NUM_REGS read/write control registers,
// oversampled in the clk domain, with frame-length checking on ncs rise.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                 NUM_REGS    = 8,
    parameter int                 ADDR_W      = 7,
    parameter int                 DATA_W      = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int FB    = frame_bits(ADDR_W, DATA_W);
    localparam int CNT_W = $clog2(FB + 2);

    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FB);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FB + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic copi_lvl, copi_rise, copi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ncs),
        .level (ncs_lvl),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (copi),
        .level (copi_lvl),
        .rise  (copi_rise),
        .fall  (copi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_lvl, copi_rise, copi_fall};

    state_t              state_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [FB-1:0]       rx_sr_q;
    logic [FB-1:0]       rx_next;
    logic [DATA_W-1:0]   tx_sr_q;
    logic                oe_q;
    logic [DATA_W-1:0]   reg_q [NUM_REGS];

    logic                frame_rw;
    logic [ADDR_W-1:0]   frame_addr;
    logic [DATA_W-1:0]   frame_data;

    logic                wr_vld_p1;
    logic                err_vld_p1;
    logic [ADDR_W-1:0]   wr_addr_p1;
    logic [DATA_W-1:0]   wr_data_p1;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i == int'(a)) v = reg_q[i];
        end
        return v;
    endfunction

    assign rx_next    = {rx_sr_q[FB-2:0], copi_lvl};
    assign frame_rw   = rx_sr_q[FB-1];
    assign frame_addr = rx_sr_q[DATA_W +: ADDR_W];
    assign frame_data = rx_sr_q[DATA_W-1:0];

    // Stage p0 -> p1: frame FSM, shifters and commit decision on ncs rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            oe_q       <= 1'b0;
            wr_vld_p1  <= 1'b0;
            err_vld_p1 <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_vld_p1  <= 1'b0;
            err_vld_p1 <= 1'b0;
            if (ncs_rise) begin
                state_q    <= IDLE;
                oe_q       <= 1'b0;
                wr_vld_p1  <= (state_q == FULL) && (frame_rw == RW_WRITE) &&
                              addr_ok(frame_addr);
                err_vld_p1 <= (state_q == CMD) || (state_q == DATA) ||
                              (state_q == OVERRUN);
                wr_addr_p1 <= frame_addr;
                wr_data_p1 <= frame_data;
            end else if (ncs_fall) begin
                state_q   <= CMD;
                bit_cnt_q <= '0;
                oe_q      <= 1'b0;
            end else if (!ncs_lvl && state_q != IDLE) begin
                if (sclk_rise) begin
                    if (bit_cnt_q != CNT_SAT) bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q < CNT_FULL) rx_sr_q <= rx_next;
                    case (state_q)
                        CMD: begin
                            if ((bit_cnt_q + 1'b1) == CNT_ADDR) begin
                                state_q <= DATA;
                                // Read: present data starting on the next falling sclk
                                if (rx_next[ADDR_W] != RW_WRITE) begin
                                    tx_sr_q <= read_reg(rx_next[ADDR_W-1:0]);
                                    oe_q    <= 1'b1;
                                end
                            end
                        end
                        DATA: begin
                            if ((bit_cnt_q + 1'b1) == CNT_FULL) state_q <= FULL;
                        end
                        FULL:    state_q <= OVERRUN;
                        default: ;
                    endcase
                end else if (sclk_fall && oe_q && bit_cnt_q > CNT_ADDR) begin
                    tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    // Stage p1 -> p2: register write, strobes and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= RESET_VAL;
            wr_strobe <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= '0;
            frame_err <= err_vld_p1;
            if (wr_vld_p1) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (i == int'(wr_addr_p1)) begin
                        reg_q[i]     <= wr_data_p1;
                        wr_strobe[i] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs[g*DATA_W +: DATA_W] = reg_q[g];
    end

    assign cipo    = oe_q & tx_sr_q[DATA_W-1];
    assign cipo_oe = oe_q;

endmodule
